// File: rtl/key_pkg.sv
// Shared constants and types for the KEY debouncer.
package key_pkg;

    localparam logic        KEY_RELEASED         = 1'b1;
    localparam int unsigned KEY_DEBOUNCE_DEFAULT = 500000;

    typedef enum logic {
        STABLE,
        PENDING
    } key_deb_state_t;

endpackage

// File: rtl/key_debounce_bit.sv
// One KEY channel: 2-flop synchroniser, disagreement counter, level and edge pulses.
module key_debounce_bit
    import key_pkg::*;
#(
    parameter int unsigned  DEBOUNCE_CYCLES = KEY_DEBOUNCE_DEFAULT,
    localparam int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic clk,
    input  logic reset_n,
    input  logic key_raw,
    output logic key_level,
    output logic press_pulse,
    output logic release_pulse
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             s1;
    logic             s2;
    logic [CNT_W-1:0] cnt;

    key_deb_state_t   state_c;
    logic [CNT_W-1:0] cnt_nxt;
    logic             level_nxt;
    logic             press_nxt;
    logic             release_nxt;

    // Synchroniser and registered debounce state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1            <= KEY_RELEASED;
            s2            <= KEY_RELEASED;
            key_level     <= KEY_RELEASED;
            cnt           <= '0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            s1            <= key_raw;
            s2            <= s1;
            key_level     <= level_nxt;
            cnt           <= cnt_nxt;
            press_pulse   <= press_nxt;
            release_pulse <= release_nxt;
        end
    end

    // Count consecutive disagreement; accept after DEBOUNCE_CYCLES of it, clear on any bounce.
    always_comb begin
        state_c     = (s2 != key_level) ? PENDING : STABLE;
        cnt_nxt     = '0;
        level_nxt   = key_level;
        press_nxt   = 1'b0;
        release_nxt = 1'b0;
        if (state_c == PENDING) begin
            if (cnt == CNT_LAST) begin
                level_nxt   = s2;
                press_nxt   = (s2 != KEY_RELEASED);
                release_nxt = (s2 == KEY_RELEASED);
            end else begin
                cnt_nxt = cnt + CNT_W'(1);
            end
        end
    end

    // Edge pulses are mutually exclusive and the counter never passes its terminal value.
    always_ff @(posedge clk) begin
        if (reset_n) begin
            assert (!(press_pulse && release_pulse));
            assert (cnt <= CNT_LAST);
        end
    end

endmodule

// File: rtl/key_debounce.sv
// WIDTH independent KEY debounce channels feeding the KEY PIO in_port.
module key_debounce
    import key_pkg::*;
#(
    parameter int unsigned WIDTH           = 2,
    parameter int unsigned DEBOUNCE_CYCLES = KEY_DEBOUNCE_DEFAULT
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] key_raw,
    output logic [WIDTH-1:0] key_level,
    output logic [WIDTH-1:0] press_pulse,
    output logic [WIDTH-1:0] release_pulse
);

    // One debouncer per key.
    for (genvar i = 0; i < WIDTH; i++) begin : g_chan
        key_debounce_bit #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_bit (
            .clk           (clk),
            .reset_n       (reset_n),
            .key_raw       (key_raw[i]),
            .key_level     (key_level[i]),
            .press_pulse   (press_pulse[i]),
            .release_pulse (release_pulse[i])
        );
    end

endmodule

// File: tb/tb_key_debounce.sv
// Randomised and directed checks of key_debounce against a sliding-window reference model.
module tb_key_debounce;

    localparam int unsigned W = 2;
    localparam int unsigned D = 4;

    logic         clk = 1'b0;
    logic         reset_n;
    logic [W-1:0] key_raw;
    logic [W-1:0] key_level;
    logic [W-1:0] press_pulse;
    logic [W-1:0] release_pulse;

    int total = 0;
    int bad   = 0;

    key_debounce #(
        .WIDTH           (W),
        .DEBOUNCE_CYCLES (D)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .key_raw       (key_raw),
        .key_level     (key_level),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse)
    );

    always #5 clk = ~clk;

    // Reference: samp[0] is the latest raw sample, samp[k] the sample k edges older.
    // A level flips when the last D synchronised values all differ from it.
    logic [W-1:0] samp [0:D];
    logic [W-1:0] m_level;
    logic [W-1:0] m_press;
    logic [W-1:0] m_release;

    function automatic logic [W-1:0] window_flip();
        logic [W-1:0] f;
        f = '1;
        for (int k = 1; k <= int'(D); k++) f = f & (samp[k] ^ m_level);
        return f;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k <= int'(D); k++) samp[k] <= '1;
            m_level   <= '1;
            m_press   <= '0;
            m_release <= '0;
        end else begin
            m_level   <= m_level ^ window_flip();
            m_press   <= window_flip() & m_level;
            m_release <= window_flip() & ~m_level;
            samp[0]   <= key_raw;
            for (int k = 1; k <= int'(D); k++) samp[k] <= samp[k-1];
        end
    end

    // Drive one cycle of input at the falling edge and return at the next falling edge.
    task automatic step(input logic [W-1:0] raw);
        key_raw = raw;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        int first = 0;
        int npress = 0;
        reset_n = 1'b0;
        key_raw = 2'b00;
        @(negedge clk);
        @(negedge clk);
        total++;
        if (key_level !== 2'b11 || press_pulse !== 2'b00 || release_pulse !== 2'b00) begin
            bad++;
            $display("FAIL reset_values: got lvl=%b prs=%b rel=%b want lvl=11 prs=00 rel=00",
                     key_level, press_pulse, release_pulse);
        end
        reset_n = 1'b1;
        for (int n = 1; n <= 12; n++) begin
            step(2'b00);
            total++;
            if ({key_level, press_pulse, release_pulse} !== {m_level, m_press, m_release}) begin
                bad++;
                $display("FAIL reset_model n=%0d: got %b/%b/%b want %b/%b/%b", n,
                         key_level, press_pulse, release_pulse, m_level, m_press, m_release);
            end
            if (press_pulse == 2'b11) begin
                npress++;
                if (first == 0) first = n;
            end
        end
        total++;
        if (first != int'(D) + 2 || npress != 1) begin
            bad++;
            $display("FAIL reset_held_press: got edge=%0d count=%0d want edge=%0d count=1",
                     first, npress, D + 2);
        end
        total++;
        if (key_level !== 2'b00) begin
            bad++;
            $display("FAIL reset_held_level: got %b want 00", key_level);
        end
    endtask

    task automatic test_release();
        int nrel = 0;
        int nprs = 0;
        for (int n = 1; n <= 10; n++) begin
            step(2'b10);
            total++;
            if ({key_level, press_pulse, release_pulse} !== {m_level, m_press, m_release}) begin
                bad++;
                $display("FAIL release_model n=%0d: got %b/%b/%b want %b/%b/%b", n,
                         key_level, press_pulse, release_pulse, m_level, m_press, m_release);
            end
            if (release_pulse[1]) nrel++;
            if (press_pulse != 2'b00) nprs++;
        end
        total++;
        if (nrel != 1 || nprs != 0 || key_level !== 2'b10) begin
            bad++;
            $display("FAIL release_ch1: got rel=%0d prs=%0d lvl=%b want rel=1 prs=0 lvl=10",
                     nrel, nprs, key_level);
        end
        for (int n = 1; n <= 10; n++) step(2'b11);
        total++;
        if (key_level !== 2'b11) begin
            bad++;
            $display("FAIL release_all: got %b want 11", key_level);
        end
    endtask

    task automatic test_clean_press();
        int first = 0;
        int npress = 0;
        int ch1_bad = 0;
        for (int n = 1; n <= 12; n++) begin
            step(2'b10);
            total++;
            if ({key_level, press_pulse, release_pulse} !== {m_level, m_press, m_release}) begin
                bad++;
                $display("FAIL press_model n=%0d: got %b/%b/%b want %b/%b/%b", n,
                         key_level, press_pulse, release_pulse, m_level, m_press, m_release);
            end
            if (press_pulse[0]) begin
                npress++;
                if (first == 0) first = n;
            end
            if (key_level[1] !== 1'b1 || press_pulse[1] || release_pulse[1]) ch1_bad++;
        end
        total++;
        if (first != int'(D) + 2 || npress != 1 || ch1_bad != 0) begin
            bad++;
            $display("FAIL clean_press: got edge=%0d count=%0d ch1_err=%0d want edge=%0d count=1 ch1_err=0",
                     first, npress, ch1_bad, D + 2);
        end
    endtask

    task automatic test_bounce();
        int glitch = 0;
        int first = 0;
        for (int n = 1; n <= 10; n++) step(2'b11);
        for (int r = 0; r < 6; r++) begin
            for (int k = 0; k < 4; k++) begin
                step((k < 3) ? 2'b10 : 2'b11);
                total++;
                if ({key_level, press_pulse, release_pulse} !== {m_level, m_press, m_release}) begin
                    bad++;
                    $display("FAIL bounce_model r=%0d k=%0d: got %b/%b/%b want %b/%b/%b", r, k,
                             key_level, press_pulse, release_pulse, m_level, m_press, m_release);
                end
                if (key_level !== 2'b11 || press_pulse != 2'b00 || release_pulse != 2'b00) glitch++;
            end
        end
        total++;
        if (glitch != 0) begin
            bad++;
            $display("FAIL bounce_reject: got %0d disturbed cycles want 0", glitch);
        end
        for (int n = 1; n <= 10; n++) begin
            step(2'b10);
            if (press_pulse[0] && first == 0) first = n;
        end
        total++;
        if (first != int'(D) + 2) begin
            bad++;
            $display("FAIL bounce_then_stable: got edge=%0d want %0d", first, D + 2);
        end
    endtask

    task automatic test_simultaneous();
        int first = 0;
        logic [W-1:0] prev_level;
        logic [W-1:0] lvl_at_pulse = '1;
        logic [W-1:0] lvl_before = '0;
        for (int n = 1; n <= 10; n++) step(2'b11);
        for (int n = 1; n <= 12; n++) begin
            prev_level = key_level;
            step(2'b00);
            total++;
            if ({key_level, press_pulse, release_pulse} !== {m_level, m_press, m_release}) begin
                bad++;
                $display("FAIL simul_model n=%0d: got %b/%b/%b want %b/%b/%b", n,
                         key_level, press_pulse, release_pulse, m_level, m_press, m_release);
            end
            if (press_pulse != 2'b00 && first == 0) begin
                first = n;
                lvl_at_pulse = key_level;
                lvl_before = prev_level;
                total++;
                if (press_pulse !== 2'b11) begin
                    bad++;
                    $display("FAIL simul_pulse: got %b want 11", press_pulse);
                end
            end
        end
        total++;
        if (first != int'(D) + 2 || lvl_at_pulse !== 2'b00 || lvl_before !== 2'b11) begin
            bad++;
            $display("FAIL simul_levels: got edge=%0d before=%b after=%b want edge=%0d before=11 after=00",
                     first, lvl_before, lvl_at_pulse, D + 2);
        end
    endtask

    task automatic test_reset_mid();
        int first = 0;
        for (int n = 1; n <= 10; n++) step(2'b11);
        for (int n = 1; n <= 4; n++) step(2'b10);
        reset_n = 1'b0;
        #1;
        total++;
        if (key_level[0] !== 1'b1 || press_pulse !== 2'b00 || release_pulse !== 2'b00) begin
            bad++;
            $display("FAIL reset_mid_assert: got lvl=%b prs=%b rel=%b want lvl[0]=1 prs=00 rel=00",
                     key_level, press_pulse, release_pulse);
        end
        @(posedge clk);
        @(negedge clk);
        total++;
        if (key_level !== 2'b11 || press_pulse !== 2'b00) begin
            bad++;
            $display("FAIL reset_mid_hold: got lvl=%b prs=%b want lvl=11 prs=00", key_level, press_pulse);
        end
        reset_n = 1'b1;
        for (int n = 1; n <= 12; n++) begin
            step(2'b10);
            total++;
            if ({key_level, press_pulse, release_pulse} !== {m_level, m_press, m_release}) begin
                bad++;
                $display("FAIL reset_mid_model n=%0d: got %b/%b/%b want %b/%b/%b", n,
                         key_level, press_pulse, release_pulse, m_level, m_press, m_release);
            end
            if (press_pulse[0] && first == 0) first = n;
        end
        total++;
        if (first != int'(D) + 2) begin
            bad++;
            $display("FAIL reset_mid_press: got edge=%0d want %0d", first, D + 2);
        end
    endtask

    task automatic test_random();
        logic [W-1:0] raw = '1;
        int hold [W];
        int both = 0;
        for (int c = 0; c < int'(W); c++) hold[c] = 0;
        for (int n = 0; n < 800; n++) begin
            for (int c = 0; c < int'(W); c++) begin
                if (hold[c] == 0) begin
                    raw[c] = ~raw[c];
                    hold[c] = int'($urandom_range(1, 2 * D + 1));
                end
                hold[c]--;
            end
            step(raw);
            total++;
            if ({key_level, press_pulse, release_pulse} !== {m_level, m_press, m_release}) begin
                bad++;
                $display("FAIL random_model n=%0d: got %b/%b/%b want %b/%b/%b", n,
                         key_level, press_pulse, release_pulse, m_level, m_press, m_release);
            end
            if ((press_pulse & release_pulse) != '0) both++;
        end
        total++;
        if (both != 0) begin
            bad++;
            $display("FAIL random_exclusive: got %0d overlapping cycles want 0", both);
        end
    endtask

    initial begin
        reset_n = 1'b0;
        key_raw = '1;
        @(negedge clk);
        test_reset();
        test_release();
        test_clean_press();
        test_bounce();
        test_simultaneous();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
